// File: rtl/lsu_mem_arbiter.sv
// rtl/lsu_mem_arbiter.sv - three-requester (fetch/load/store) arbiter onto one memory port
//
// Purpose: grants one of fetch, load or store to a single shared memory port,
// with one transaction outstanding at a time. Priority is store > load > fetch,
// except that fetch is promoted after STARVE_LIMIT consecutive losses.
//
// Ports:
//   clock, reset_n                      - clock, asynchronous active-low reset
//   opfetch_*  (valid/index -> ready/operation_done/read_data)  fetch requester
//   opload_*   (valid/index -> ready/operation_done/read_data)  load requester
//   opstore_*  (valid/index/write_mask/write_data -> ready/operation_done)
//   mem_req_*  (valid/is_write/index/wmask/wdata, ready)        memory request
//   mem_rsp_*  (done/rdata)                                     memory response
module lsu_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        opfetch_index_valid,
    input  logic [18:0] opfetch_index,
    output logic        opfetch_index_ready,
    output logic        opfetch_operation_done,
    output logic [63:0] opfetch_read_data,
    input  logic        opload_index_valid,
    input  logic [18:0] opload_index,
    output logic        opload_index_ready,
    output logic        opload_operation_done,
    output logic [63:0] opload_read_data,
    input  logic        opstore_index_valid,
    input  logic [18:0] opstore_index,
    input  logic [63:0] opstore_write_mask,
    input  logic [63:0] opstore_write_data,
    output logic        opstore_index_ready,
    output logic        opstore_operation_done,
    output logic        mem_req_valid,
    output logic        mem_req_is_write,
    output logic [18:0] mem_req_index,
    output logic [63:0] mem_req_wmask,
    output logic [63:0] mem_req_wdata,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_done,
    input  logic [63:0] mem_rsp_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;

    localparam int              CW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   STARVE_MAX = CW'(STARVE_LIMIT);
    localparam logic [1:0]      G_NONE     = 2'd0;
    localparam logic [1:0]      G_FETCH    = 2'd1;
    localparam logic [1:0]      G_LOAD     = 2'd2;
    localparam logic [1:0]      G_STORE    = 2'd3;

    state_t        r_state;
    state_t        w_next_state;
    logic [1:0]    r_grant;
    logic [18:0]   r_index;
    logic          r_is_write;
    logic [63:0]   r_wmask;
    logic [63:0]   r_wdata;
    logic [63:0]   r_fetch_rdata;
    logic [63:0]   r_load_rdata;
    logic [CW-1:0] r_starve;

    logic [1:0]    w_winner;
    logic          w_idle;
    logic          w_hs;
    logic          w_rsp_take;

    // Winner selection; a starved fetch overrides the fixed priority.
    always_comb begin
        w_winner = G_NONE;
        if (opfetch_index_valid && (r_starve == STARVE_MAX)) begin
            w_winner = G_FETCH;
        end else if (opstore_index_valid) begin
            w_winner = G_STORE;
        end else if (opload_index_valid) begin
            w_winner = G_LOAD;
        end else if (opfetch_index_valid) begin
            w_winner = G_FETCH;
        end
    end

    // reset_n gates the readies so every output is 0 while reset is held.
    assign w_idle = (r_state == ST_IDLE) && reset_n;
    assign w_hs   = w_idle && (w_winner != G_NONE);

    assign opfetch_index_ready = w_idle && (w_winner == G_FETCH);
    assign opload_index_ready  = w_idle && (w_winner == G_LOAD);
    assign opstore_index_ready = w_idle && (w_winner == G_STORE);

    assign opfetch_read_data = r_fetch_rdata;
    assign opload_read_data  = r_load_rdata;

    assign mem_req_is_write = mem_req_valid && r_is_write;
    assign mem_req_index    = mem_req_valid ? r_index : 19'd0;
    assign mem_req_wmask    = mem_req_valid ? r_wmask : 64'd0;
    assign mem_req_wdata    = mem_req_valid ? r_wdata : 64'd0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state           = r_state;
        mem_req_valid          = 1'b0;
        opfetch_operation_done = 1'b0;
        opload_operation_done  = 1'b0;
        opstore_operation_done = 1'b0;
        w_rsp_take             = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    if (mem_rsp_done) begin
                        w_next_state = ST_RESP;
                        w_rsp_take   = 1'b1;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_rsp_done) begin
                    w_next_state = ST_RESP;
                    w_rsp_take   = 1'b1;
                end
            end
            ST_RESP: begin
                opfetch_operation_done = (r_grant == G_FETCH);
                opload_operation_done  = (r_grant == G_LOAD);
                opstore_operation_done = (r_grant == G_STORE);
                w_next_state           = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_grant       <= G_NONE;
            r_index       <= 19'd0;
            r_is_write    <= 1'b0;
            r_wmask       <= 64'd0;
            r_wdata       <= 64'd0;
            r_fetch_rdata <= 64'd0;
            r_load_rdata  <= 64'd0;
            r_starve      <= '0;
        end else begin
            if (w_hs) begin
                r_grant    <= w_winner;
                r_is_write <= (w_winner == G_STORE);
                r_wmask    <= (w_winner == G_STORE) ? opstore_write_mask : 64'd0;
                r_wdata    <= (w_winner == G_STORE) ? opstore_write_data : 64'd0;
                case (w_winner)
                    G_STORE: r_index <= opstore_index;
                    G_LOAD:  r_index <= opload_index;
                    default: r_index <= opfetch_index;
                endcase
                // Count only grants that fetch lost while it was waiting.
                if (w_winner == G_FETCH) begin
                    r_starve <= '0;
                end else if (opfetch_index_valid && (r_starve != STARVE_MAX)) begin
                    r_starve <= r_starve + CW'(1);
                end
            end
            if (w_rsp_take) begin
                if (r_grant == G_FETCH) begin
                    r_fetch_rdata <= mem_rsp_rdata;
                end
                if (r_grant == G_LOAD) begin
                    r_load_rdata <= mem_rsp_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb/tb_lsu_mem_arbiter.sv - directed self-checking bench for lsu_mem_arbiter
module tb_lsu_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        opfetch_index_valid;
    logic [18:0] opfetch_index;
    logic        opfetch_index_ready;
    logic        opfetch_operation_done;
    logic [63:0] opfetch_read_data;
    logic        opload_index_valid;
    logic [18:0] opload_index;
    logic        opload_index_ready;
    logic        opload_operation_done;
    logic [63:0] opload_read_data;
    logic        opstore_index_valid;
    logic [18:0] opstore_index;
    logic [63:0] opstore_write_mask;
    logic [63:0] opstore_write_data;
    logic        opstore_index_ready;
    logic        opstore_operation_done;
    logic        mem_req_valid;
    logic        mem_req_is_write;
    logic [18:0] mem_req_index;
    logic [63:0] mem_req_wmask;
    logic [63:0] mem_req_wdata;
    logic        mem_req_ready;
    logic        mem_rsp_done;
    logic [63:0] mem_rsp_rdata;

    int checks = 0;
    int errors = 0;

    lsu_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .opfetch_index_valid    (opfetch_index_valid),
        .opfetch_index          (opfetch_index),
        .opfetch_index_ready    (opfetch_index_ready),
        .opfetch_operation_done (opfetch_operation_done),
        .opfetch_read_data      (opfetch_read_data),
        .opload_index_valid     (opload_index_valid),
        .opload_index           (opload_index),
        .opload_index_ready     (opload_index_ready),
        .opload_operation_done  (opload_operation_done),
        .opload_read_data       (opload_read_data),
        .opstore_index_valid    (opstore_index_valid),
        .opstore_index          (opstore_index),
        .opstore_write_mask     (opstore_write_mask),
        .opstore_write_data     (opstore_write_data),
        .opstore_index_ready    (opstore_index_ready),
        .opstore_operation_done (opstore_operation_done),
        .mem_req_valid          (mem_req_valid),
        .mem_req_is_write       (mem_req_is_write),
        .mem_req_index          (mem_req_index),
        .mem_req_wmask          (mem_req_wmask),
        .mem_req_wdata          (mem_req_wdata),
        .mem_req_ready          (mem_req_ready),
        .mem_rsp_done           (mem_rsp_done),
        .mem_rsp_rdata          (mem_rsp_rdata)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_dones(input string tag, input logic [2:0] exp_fls);
        chk({tag, "_fetch_done"}, 64'(opfetch_operation_done), 64'(exp_fls[2]));
        chk({tag, "_load_done"},  64'(opload_operation_done),  64'(exp_fls[1]));
        chk({tag, "_store_done"}, 64'(opstore_operation_done), 64'(exp_fls[0]));
    endtask

    task automatic chk_readies(input string tag, input logic [2:0] exp_fls);
        chk({tag, "_fetch_rdy"}, 64'(opfetch_index_ready), 64'(exp_fls[2]));
        chk({tag, "_load_rdy"},  64'(opload_index_ready),  64'(exp_fls[1]));
        chk({tag, "_store_rdy"}, 64'(opstore_index_ready), 64'(exp_fls[0]));
    endtask

    initial begin
        reset_n             = 1'b0;
        opfetch_index_valid = 1'b0;
        opfetch_index       = 19'h0;
        opload_index_valid  = 1'b0;
        opload_index        = 19'h0;
        opstore_index_valid = 1'b0;
        opstore_index       = 19'h0;
        opstore_write_mask  = 64'h0;
        opstore_write_data  = 64'h0;
        mem_req_ready       = 1'b0;
        mem_rsp_done        = 1'b0;
        mem_rsp_rdata       = 64'h0;
        step();
        step();
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_fetch_data", opfetch_read_data, 64'd0);
        chk("rst_load_data", opload_read_data, 64'd0);
        chk_dones("rst", 3'b000);
        reset_n = 1'b1;

        // All three valid together: store wins.
        opfetch_index_valid = 1'b1; opfetch_index = 19'h00111;
        opload_index_valid  = 1'b1; opload_index  = 19'h00222;
        opstore_index_valid = 1'b1; opstore_index = 19'h00333;
        opstore_write_mask  = 64'h0000_0000_FFFF_FFFF;
        opstore_write_data  = 64'h1122_3344_5566_7788;
        #1;
        chk_readies("all3", 3'b001);
        step();
        opstore_index_valid = 1'b0;
        chk("st_req_valid", 64'(mem_req_valid), 64'd1);
        chk("st_is_write", 64'(mem_req_is_write), 64'd1);
        chk("st_index", 64'(mem_req_index), 64'h333);
        chk("st_wmask", mem_req_wmask, 64'h0000_0000_FFFF_FFFF);
        chk("st_wdata", mem_req_wdata, 64'h1122_3344_5566_7788);
        chk_readies("st_busy", 3'b000);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("st_wait_valid", 64'(mem_req_valid), 64'd0);
        chk_dones("st_wait", 3'b000);
        mem_rsp_done = 1'b1;
        step();
        mem_rsp_done = 1'b0;
        chk_dones("st_resp", 3'b001);
        step();
        chk_dones("st_after", 3'b000);
        opfetch_index_valid = 1'b0;
        opload_index_valid  = 1'b0;

        // Load, minimum latency, data returned in cycle 2.
        opload_index_valid = 1'b1; opload_index = 19'h01234;
        mem_req_ready = 1'b1; mem_rsp_done = 1'b1;
        mem_rsp_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        #1;
        chk_readies("ld_c0", 3'b010);
        step();
        opload_index_valid = 1'b0;
        chk("ld_c1_valid", 64'(mem_req_valid), 64'd1);
        chk("ld_c1_index", 64'(mem_req_index), 64'h1234);
        chk("ld_c1_is_write", 64'(mem_req_is_write), 64'd0);
        chk("ld_c1_wmask", mem_req_wmask, 64'd0);
        chk("ld_c1_wdata", mem_req_wdata, 64'd0);
        step();
        mem_req_ready = 1'b0; mem_rsp_done = 1'b0;
        mem_rsp_rdata = 64'h0;
        chk_dones("ld_c2", 3'b010);
        chk("ld_c2_data", opload_read_data, 64'hDEAD_BEEF_CAFE_F00D);
        chk("ld_c2_fetch_data", opfetch_read_data, 64'd0);
        step();
        chk_dones("ld_c3", 3'b000);
        chk("ld_c3_data", opload_read_data, 64'hDEAD_BEEF_CAFE_F00D);

        // Fetch with mem_req_ready stalled for 5 cycles.
        opfetch_index_valid = 1'b1; opfetch_index = 19'h7ABCD;
        #1;
        chk_readies("fe_c0", 3'b100);
        step();
        opfetch_index_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(mem_req_valid), 64'd1);
            chk("stall_index", 64'(mem_req_index), 64'h7ABCD);
            step();
        end
        mem_req_ready = 1'b1;
        mem_rsp_rdata = 64'h0123_4567_89AB_CDEF;
        #1;
        chk("stall_end_valid", 64'(mem_req_valid), 64'd1);
        step();
        mem_req_ready = 1'b0;
        chk("fe_wait_valid", 64'(mem_req_valid), 64'd0);
        mem_rsp_done = 1'b1;
        step();
        mem_rsp_done = 1'b0;
        mem_rsp_rdata = 64'h0;
        chk_dones("fe_resp", 3'b100);
        chk("fe_data", opfetch_read_data, 64'h0123_4567_89AB_CDEF);
        chk("fe_load_data_held", opload_read_data, 64'hDEAD_BEEF_CAFE_F00D);
        step();

        // A store completing leaves the fetch data untouched.
        opstore_index_valid = 1'b1; opstore_index = 19'h00044;
        #1;
        chk_readies("st2_c0", 3'b001);
        step();
        opstore_index_valid = 1'b0;
        mem_req_ready = 1'b1; mem_rsp_done = 1'b1;
        mem_rsp_rdata = 64'hFFFF_0000_FFFF_0000;
        step();
        mem_req_ready = 1'b0; mem_rsp_done = 1'b0;
        chk_dones("st2_resp", 3'b001);
        chk("st2_fetch_data", opfetch_read_data, 64'h0123_4567_89AB_CDEF);
        chk("st2_load_data", opload_read_data, 64'hDEAD_BEEF_CAFE_F00D);
        step();

        // Starvation: four store grants while fetch waits, then fetch wins.
        opfetch_index_valid = 1'b1; opfetch_index = 19'h05555;
        opload_index_valid  = 1'b1; opload_index  = 19'h06666;
        opstore_index_valid = 1'b1; opstore_index = 19'h07777;
        mem_req_ready = 1'b1; mem_rsp_done = 1'b1;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk_readies("starve_grant", 3'b001);
            step();
            step();
            step();
        end
        #1;
        chk_readies("starve_5th", 3'b100);
        step();
        chk("starve_5th_index", 64'(mem_req_index), 64'h5555);
        step();
        chk_dones("starve_5th_resp", 3'b100);
        step();
        #1;
        chk_readies("starve_cleared", 3'b001);
        step();
        opfetch_index_valid = 1'b0;
        opload_index_valid  = 1'b0;
        opstore_index_valid = 1'b0;
        step();
        step();
        mem_req_ready = 1'b0; mem_rsp_done = 1'b0;

        // Reset while waiting for a response; the late response must be ignored.
        opload_index_valid = 1'b1; opload_index = 19'h00ABC;
        step();
        opload_index_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("wait_pre_rst_valid", 64'(mem_req_valid), 64'd0);
        reset_n = 1'b0;
        #1;
        chk("rstw_fetch_data", opfetch_read_data, 64'd0);
        chk("rstw_load_data", opload_read_data, 64'd0);
        chk("rstw_req_valid", 64'(mem_req_valid), 64'd0);
        chk_dones("rstw", 3'b000);
        step();
        reset_n = 1'b1;
        mem_rsp_done = 1'b1;
        mem_rsp_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
        step();
        chk_dones("post_rst1", 3'b000);
        chk("post_rst_valid", 64'(mem_req_valid), 64'd0);
        step();
        mem_rsp_done = 1'b0;
        chk_dones("post_rst2", 3'b000);
        chk("post_rst_load_data", opload_read_data, 64'd0);
        opfetch_index_valid = 1'b1;
        #1;
        chk_readies("post_rst_idle", 3'b100);
        opfetch_index_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
